// File: rtl/slot_payout_scorer.sv
// rtl/slot_payout_scorer.sv - slot round scorer: owns credit, debits bet, scores reels, pays out one credit per clock.
// Optional SLOT_STATS_EN adds rounds_played/wins counters.
module slot_payout_scorer #(
  parameter int CREDIT_W    = 8,
  parameter int INIT_CREDIT = 10,
  parameter int BET         = 1,
  parameter int SETTLE_CYC  = 4,
  parameter int PAY_PAIR    = 1,
  parameter int PAY_TRIPLE  = 4,
  parameter int PAY_JACKPOT = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                round_start,
  input  logic                spin_done,
  input  logic [3:0]          h,
  input  logic [3:0]          m,
  input  logic [3:0]          l,
  output logic [CREDIT_W-1:0] credit,
  output logic                round_active,
  output logic                pay_busy,
  output logic [1:0]          win_code,
  output logic                no_credit
`ifdef SLOT_STATS_EN
  ,
  output logic [7:0]          rounds_played,
  output logic [7:0]          wins
`endif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SPIN   = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_EVAL   = 3'd3;
  localparam logic [2:0] S_PAY    = 3'd4;

  localparam logic [CREDIT_W-1:0] CREDIT_MAX  = '1;
  localparam logic [CREDIT_W-1:0] CREDIT_INIT = CREDIT_W'(INIT_CREDIT);
  localparam logic [CREDIT_W-1:0] BET_C       = CREDIT_W'(BET);
  localparam logic [3:0]          SETTLE_C    = 4'(SETTLE_CYC);
  localparam logic [7:0]          AMT_PAIR    = 8'(PAY_PAIR);
  localparam logic [7:0]          AMT_TRIPLE  = 8'(PAY_TRIPLE);
  localparam logic [7:0]          AMT_JACKPOT = 8'(PAY_JACKPOT);

  logic [2:0]          state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [3:0]          settle_cnt_q, settle_cnt_d;
  logic [7:0]          pay_cnt_q, pay_cnt_d;
  logic [3:0]          h_s_q, h_s_d, m_s_q, m_s_d, l_s_q, l_s_d;
  logic [1:0]          win_code_q, win_code_d;
  logic                no_credit_q, no_credit_d;

  logic                accept;
  logic [1:0]          eval_code;
  logic [7:0]          eval_amt;

  // Scoring looks only at the sampled reels, never the live inputs.
  always_comb begin
    eval_code = 2'd0;
    eval_amt  = 8'd0;
    if (h_s_q == m_s_q && m_s_q == l_s_q) begin
      if (h_s_q == 4'd3) begin
        eval_code = 2'd3;
        eval_amt  = AMT_JACKPOT;
      end else begin
        eval_code = 2'd2;
        eval_amt  = AMT_TRIPLE;
      end
    end else if (h_s_q == m_s_q || m_s_q == l_s_q || h_s_q == l_s_q) begin
      eval_code = 2'd1;
      eval_amt  = AMT_PAIR;
    end
  end

  always_comb begin
    state_d      = state_q;
    credit_d     = credit_q;
    settle_cnt_d = settle_cnt_q;
    pay_cnt_d    = pay_cnt_q;
    h_s_d        = h_s_q;
    m_s_d        = m_s_q;
    l_s_d        = l_s_q;
    win_code_d   = win_code_q;
    no_credit_d  = 1'b0;
    accept       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (round_start) begin
          if (credit_q >= BET_C) begin
            accept     = 1'b1;
            credit_d   = credit_q - BET_C;
            win_code_d = 2'd0;
            state_d    = S_SPIN;
          end else begin
            no_credit_d = 1'b1;
          end
        end
      end
      S_SPIN: begin
        if (spin_done) begin
          settle_cnt_d = SETTLE_C;
          state_d      = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_cnt_q == 4'd0) begin
          h_s_d   = h;
          m_s_d   = m;
          l_s_d   = l;
          state_d = S_EVAL;
        end else begin
          settle_cnt_d = settle_cnt_q - 4'd1;
        end
      end
      S_EVAL: begin
        win_code_d = eval_code;
        if (eval_amt == 8'd0) begin
          state_d = S_IDLE;
        end else begin
          pay_cnt_d = eval_amt;
          state_d   = S_PAY;
        end
      end
      S_PAY: begin
        // Saturated credit still burns the remaining payout cycles.
        if (credit_q != CREDIT_MAX) credit_d = credit_q + 1'b1;
        pay_cnt_d = pay_cnt_q - 8'd1;
        if (pay_cnt_q <= 8'd1) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      credit_q     <= CREDIT_INIT;
      settle_cnt_q <= 4'd0;
      pay_cnt_q    <= 8'd0;
      h_s_q        <= 4'd0;
      m_s_q        <= 4'd0;
      l_s_q        <= 4'd0;
      win_code_q   <= 2'd0;
      no_credit_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      credit_q     <= credit_d;
      settle_cnt_q <= settle_cnt_d;
      pay_cnt_q    <= pay_cnt_d;
      h_s_q        <= h_s_d;
      m_s_q        <= m_s_d;
      l_s_q        <= l_s_d;
      win_code_q   <= win_code_d;
      no_credit_q  <= no_credit_d;
    end
  end

  assign credit       = credit_q;
  assign round_active = (state_q != S_IDLE);
  assign pay_busy     = (state_q == S_PAY);
  assign win_code     = win_code_q;
  assign no_credit    = no_credit_q;

`ifdef SLOT_STATS_EN
  logic [7:0] rounds_q, wins_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rounds_q <= 8'd0;
      wins_q   <= 8'd0;
    end else begin
      if (accept && rounds_q != 8'hFF) rounds_q <= rounds_q + 8'd1;
      if (state_q == S_EVAL && eval_code != 2'd0 && wins_q != 8'hFF) wins_q <= wins_q + 8'd1;
    end
  end

  assign rounds_played = rounds_q;
  assign wins          = wins_q;
`endif

endmodule

// File: tb/tb_slot_payout_scorer.sv
// tb/tb_slot_payout_scorer.sv - randomized self-checking bench for slot_payout_scorer against a round-level model.
module tb_slot_payout_scorer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       round_start = 1'b0;
  logic       spin_done = 1'b0;
  logic [3:0] h = 4'd0, m = 4'd0, l = 4'd0;

  logic [7:0] credit, credit2;
  logic       round_active, round_active2, pay_busy, pay_busy2, no_credit, no_credit2;
  logic [1:0] win_code, win_code2;
`ifdef SLOT_STATS_EN
  logic [7:0] rounds_played, wins, rounds_played2, wins2;
`endif

  int checks = 0;
  int failures = 0;
  int exp_credit = 10;
  int exp_credit2 = 254;
  int pay_seen2 = 0;

  always #5 clk = ~clk;

  slot_payout_scorer dut (
    .clk(clk), .rst(rst), .round_start(round_start), .spin_done(spin_done),
    .h(h), .m(m), .l(l), .credit(credit), .round_active(round_active),
    .pay_busy(pay_busy), .win_code(win_code), .no_credit(no_credit)
`ifdef SLOT_STATS_EN
    , .rounds_played(rounds_played), .wins(wins)
`endif
  );

  slot_payout_scorer #(.INIT_CREDIT(254)) dut2 (
    .clk(clk), .rst(rst), .round_start(round_start), .spin_done(spin_done),
    .h(h), .m(m), .l(l), .credit(credit2), .round_active(round_active2),
    .pay_busy(pay_busy2), .win_code(win_code2), .no_credit(no_credit2)
`ifdef SLOT_STATS_EN
    , .rounds_played(rounds_played2), .wins(wins2)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_code(input int a, input int b, input int c);
    if (a == b && b == c) return (a == 3) ? 3 : 2;
    if (a == b || b == c || a == c) return 1;
    return 0;
  endfunction

  function automatic int model_pay(input int code);
    case (code)
      3: return 8;
      2: return 4;
      1: return 1;
      default: return 0;
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b1; round_start = 1'b0; spin_done = 1'b0;
    tick(); tick();
    rst = 1'b0;
    exp_credit = 10;
    exp_credit2 = 254;
  endtask

  // Drives a complete accepted round; decoy reels surround the single sampling cycle.
  task automatic play_round(input int rh, input int rm, input int rl,
                            input bit extra_start, input bit spurious);
    int code, amt, cnt, guard;
    code = model_code(rh, rm, rl);
    amt  = model_pay(code);
    round_start = 1'b1; tick(); round_start = 1'b0;
    exp_credit -= 1;
    exp_credit2 -= 1;
    checks++;
    if (credit !== 8'(exp_credit) || round_active !== 1'b1 || win_code !== 2'd0) begin
      failures++;
      $display("FAIL debit: credit=%0d ra=%0b win=%0d required credit=%0d ra=1 win=0",
               credit, round_active, win_code, exp_credit);
    end
    if (extra_start) begin
      round_start = 1'b1; tick(); round_start = 1'b0;
    end
    tick();
    h = 4'd5; m = 4'd6; l = 4'd7;
    spin_done = 1'b1; tick(); spin_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      spin_done = (spurious && i == 1);
      tick();
    end
    spin_done = 1'b0;
    h = 4'(rh); m = 4'(rm); l = 4'(rl);
    tick();
    h = 4'd9; m = 4'd10; l = 4'd11;
    tick();
    checks++;
    if (win_code !== 2'(code)) begin
      failures++;
      $display("FAIL win_code reels=%0d,%0d,%0d: got %0d required %0d", rh, rm, rl, win_code, code);
    end
    cnt = 0; pay_seen2 = 0; guard = 0;
    while ((pay_busy === 1'b1 || pay_busy2 === 1'b1) && guard < 40) begin
      if (pay_busy === 1'b1) cnt++;
      if (pay_busy2 === 1'b1) pay_seen2++;
      tick();
      guard++;
    end
    exp_credit = (exp_credit + amt > 255) ? 255 : exp_credit + amt;
    exp_credit2 = (exp_credit2 + amt > 255) ? 255 : exp_credit2 + amt;
    checks++;
    if (cnt != amt || credit !== 8'(exp_credit) || round_active !== 1'b0) begin
      failures++;
      $display("FAIL payout reels=%0d,%0d,%0d: cycles=%0d credit=%0d ra=%0b required cycles=%0d credit=%0d ra=0",
               rh, rm, rl, cnt, credit, round_active, amt, exp_credit);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (credit !== 8'd10 || win_code !== 2'd0 || round_active !== 1'b0 ||
        pay_busy !== 1'b0 || no_credit !== 1'b0) begin
      failures++;
      $display("FAIL reset: credit=%0d win=%0d ra=%0b pb=%0b nc=%0b required 10 0 0 0 0",
               credit, win_code, round_active, pay_busy, no_credit);
    end
  endtask

  task automatic test_directed();
    do_reset(); play_round(2, 2, 2, 0, 0);
    do_reset(); play_round(3, 3, 3, 0, 0);
    do_reset(); play_round(1, 1, 2, 0, 0);
    do_reset(); play_round(0, 1, 2, 0, 0);
    play_round(4, 7, 4, 0, 0);
  endtask

  task automatic test_no_credit();
    do_reset();
    for (int i = 0; i < 10; i++) play_round(0, 1, 2, 0, 0);
    round_start = 1'b1; tick(); round_start = 1'b0;
    checks++;
    if (no_credit !== 1'b1 || round_active !== 1'b0 || credit !== 8'd0) begin
      failures++;
      $display("FAIL no_credit pulse: nc=%0b ra=%0b credit=%0d required 1 0 0", no_credit, round_active, credit);
    end
    tick();
    checks++;
    if (no_credit !== 1'b0) begin
      failures++;
      $display("FAIL no_credit width: nc=%0b required 0", no_credit);
    end
    spin_done = 1'b1; tick(); spin_done = 1'b0;
    tick();
    checks++;
    if (round_active !== 1'b0 || credit !== 8'd0 || no_credit !== 1'b0) begin
      failures++;
      $display("FAIL idle spin_done: ra=%0b credit=%0d required 0 0", round_active, credit);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    play_round(2, 2, 2, 1, 1);
    for (int i = 0; i < 20; i++) begin
      if (exp_credit < 1) do_reset();
      play_round(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_saturation();
    int guard;
    do_reset();
    play_round(3, 3, 3, 0, 0);
    checks++;
    if (pay_seen2 != 8 || credit2 !== 8'd255) begin
      failures++;
      $display("FAIL saturation: cycles=%0d credit=%0d required cycles=8 credit=255", pay_seen2, credit2);
    end
    do_reset();
    round_start = 1'b1; tick(); round_start = 1'b0;
    tick();
    spin_done = 1'b1; tick(); spin_done = 1'b0;
    h = 4'd3; m = 4'd3; l = 4'd3;
    guard = 0;
    while (pay_busy2 !== 1'b1 && guard < 40) begin
      tick();
      guard++;
    end
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if (credit2 !== 8'd254 || pay_busy2 !== 1'b0 || credit !== 8'd10 || guard >= 40) begin
      failures++;
      $display("FAIL reset mid-pay: credit2=%0d pb2=%0b credit=%0d required 254 0 10", credit2, pay_busy2, credit);
    end
    exp_credit = 10;
    exp_credit2 = 254;
  endtask

`ifdef SLOT_STATS_EN
  task automatic test_stats();
    do_reset();
    play_round(5, 5, 5, 0, 0);
    play_round(0, 1, 2, 1, 0);
    play_round(6, 1, 6, 0, 0);
    checks++;
    if (rounds_played !== 8'd3 || wins !== 8'd2) begin
      failures++;
      $display("FAIL stats: rounds=%0d wins=%0d required 3 2", rounds_played, wins);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_no_credit();
    test_back_to_back();
    test_saturation();
`ifdef SLOT_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
